// File: rtl/uart_defs_pkg.sv
// Shared definitions for the UART byte transmitter: parity modes, FSM states
// and small elaboration-time helpers.
package uart_defs;

   localparam int unsigned PARITY_NONE = 0;
   localparam int unsigned PARITY_EVEN = 1;
   localparam int unsigned PARITY_ODD  = 2;

   localparam int unsigned DATA_BITS = 8;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } tx_state_e;

   // Counter width for a modulus of n; never narrower than one bit.
   function automatic int unsigned width_for(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic logic parity_of(input logic [DATA_BITS-1:0] b,
                                      input int unsigned mode);
      return (mode == PARITY_ODD) ? ~(^b) : (^b);
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Per-bit timing for the transmitter: pulses tick_o on the last cycle of
// every CLKS_PER_BIT-cycle bit period; restart_i holds the count at zero.
module uart_baud_tick
   import uart_defs::*;
#(
   parameter int unsigned CLKS_PER_BIT = 434
) (
   input  logic clk,
   input  logic reset,
   input  logic restart_i,
   output logic tick_o
);

   localparam int unsigned     CW   = width_for(CLKS_PER_BIT);
   localparam logic [CW-1:0]   LAST = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q + CW'(1);
      if (restart_i || (cnt_q == LAST)) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick_o = (cnt_q == LAST) && !restart_i;

endmodule

// File: rtl/uart_byte_transmitter.sv
// UART byte transmitter: level-sampled start/ready handshake, 8N/8E/8O
// framing with one or two stop bits, tx and ready driven from registers.
module uart_byte_transmitter
   import uart_defs::*;
#(
   parameter int unsigned CLKS_PER_BIT = 434,
   parameter int unsigned PARITY       = 0,
   parameter int unsigned STOP_BITS    = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 tran_interface_start,
   input  logic [DATA_BITS-1:0] tran_interface_out_byte,
   output logic                 tran_interface_ready,
   output logic                 tx
);

   localparam int unsigned   SW         = width_for(STOP_BITS);
   localparam logic [SW-1:0] STOP_LAST  = SW'(STOP_BITS - 1);
   localparam bit            HAS_PARITY = (PARITY != PARITY_NONE);

   tx_state_e            state_q;
   logic [DATA_BITS-1:0] byte_q;
   logic [2:0]           bit_idx_q;
   logic [SW-1:0]        stop_cnt_q;
   logic                 tx_q;
   logic                 ready_q;
   logic                 bit_tick;
   logic                 baud_restart;

   // Bit timer is held at zero while idle, so the start bit gets a full period.
   assign baud_restart = (state_q == ST_IDLE);

   uart_baud_tick #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud_tick (
      .clk      (clk),
      .reset    (reset),
      .restart_i(baud_restart),
      .tick_o   (bit_tick)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         byte_q     <= '0;
         bit_idx_q  <= '0;
         stop_cnt_q <= '0;
         tx_q       <= 1'b1;
         ready_q    <= 1'b1;
      end else begin
         case (state_q)
            ST_IDLE: begin
               tx_q    <= 1'b1;
               ready_q <= 1'b1;
               if (tran_interface_start) begin
                  byte_q  <= tran_interface_out_byte;
                  tx_q    <= 1'b0;
                  ready_q <= 1'b0;
                  state_q <= ST_START;
               end
            end
            ST_START: begin
               if (bit_tick) begin
                  bit_idx_q <= '0;
                  tx_q      <= byte_q[0];
                  state_q   <= ST_DATA;
               end
            end
            ST_DATA: begin
               if (bit_tick) begin
                  // Index stops at 7; the last data bit hands over without wrapping.
                  if (bit_idx_q == 3'd7) begin
                     if (HAS_PARITY) begin
                        tx_q    <= parity_of(byte_q, PARITY);
                        state_q <= ST_PARITY;
                     end else begin
                        tx_q       <= 1'b1;
                        stop_cnt_q <= '0;
                        state_q    <= ST_STOP;
                     end
                  end else begin
                     bit_idx_q <= bit_idx_q + 3'd1;
                     tx_q      <= byte_q[bit_idx_q + 3'd1];
                  end
               end
            end
            ST_PARITY: begin
               if (bit_tick) begin
                  tx_q       <= 1'b1;
                  stop_cnt_q <= '0;
                  state_q    <= ST_STOP;
               end
            end
            ST_STOP: begin
               if (bit_tick) begin
                  if (stop_cnt_q == STOP_LAST) begin
                     ready_q <= 1'b1;
                     state_q <= ST_IDLE;
                  end else begin
                     stop_cnt_q <= stop_cnt_q + SW'(1);
                  end
               end
            end
            default: begin
               tx_q    <= 1'b1;
               ready_q <= 1'b1;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign tx                   = tx_q;
   assign tran_interface_ready = ready_q;

endmodule

// File: tb/tb_uart_byte_transmitter.sv
// Bench for uart_byte_transmitter: four configurations driven in lockstep and
// compared each cycle against a frame-queue reference model.
module tb_uart_byte_transmitter;

   localparam int unsigned C = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic [7:0] din = 8'h00;
   logic [3:0] tx_w;
   logic [3:0] rdy_w;

   always #5 clk = ~clk;

   uart_byte_transmitter #(.CLKS_PER_BIT(C), .PARITY(0), .STOP_BITS(1)) dut0 (
      .clk(clk), .reset(reset), .tran_interface_start(start),
      .tran_interface_out_byte(din), .tran_interface_ready(rdy_w[0]), .tx(tx_w[0]));
   uart_byte_transmitter #(.CLKS_PER_BIT(C), .PARITY(1), .STOP_BITS(1)) dut1 (
      .clk(clk), .reset(reset), .tran_interface_start(start),
      .tran_interface_out_byte(din), .tran_interface_ready(rdy_w[1]), .tx(tx_w[1]));
   uart_byte_transmitter #(.CLKS_PER_BIT(C), .PARITY(2), .STOP_BITS(1)) dut2 (
      .clk(clk), .reset(reset), .tran_interface_start(start),
      .tran_interface_out_byte(din), .tran_interface_ready(rdy_w[2]), .tx(tx_w[2]));
   uart_byte_transmitter #(.CLKS_PER_BIT(C), .PARITY(0), .STOP_BITS(2)) dut3 (
      .clk(clk), .reset(reset), .tran_interface_start(start),
      .tran_interface_out_byte(din), .tran_interface_ready(rdy_w[3]), .tx(tx_w[3]));

   int unsigned cfg_par  [4] = '{0, 1, 2, 0};
   int unsigned cfg_stop [4] = '{1, 1, 1, 2};

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
      end
   endtask

   // Reference model: on acceptance the whole frame is expanded into a queue of
   // per-cycle {tx, ready} samples, followed by the single ready-return cycle.
   logic [1:0] mq [4][$];
   logic       etx  [4];
   logic       erdy [4];
   logic       fb [$];
   logic [1:0] ent;
   int         ones;

   always @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (reset) begin
            mq[i].delete();
            etx[i]  = 1'b1;
            erdy[i] = 1'b1;
         end else begin
            if (mq[i].size() == 0 && start) begin
               fb.delete();
               fb.push_back(1'b0);
               for (int k = 0; k < 8; k++) fb.push_back(din[k]);
               ones = $countones(din);
               if (cfg_par[i] == 1) fb.push_back((ones % 2) == 1);
               if (cfg_par[i] == 2) fb.push_back((ones % 2) == 0);
               for (int s = 0; s < int'(cfg_stop[i]); s++) fb.push_back(1'b1);
               for (int b = 0; b < fb.size(); b++)
                  for (int r = 0; r < int'(C); r++) mq[i].push_back({fb[b], 1'b0});
               mq[i].push_back(2'b11);
            end
            if (mq[i].size() > 0) begin
               ent     = mq[i].pop_front();
               etx[i]  = ent[1];
               erdy[i] = ent[0];
            end else begin
               etx[i]  = 1'b1;
               erdy[i] = 1'b1;
            end
         end
      end
   end

   logic cap   [4][128];
   int   cap_n [4];

   always @(negedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (!rdy_w[i] && cap_n[i] < 128) begin
            cap[i][cap_n[i]] = tx_w[i];
            cap_n[i]++;
         end
         if (chk_en) begin
            check($sformatf("tx[%0d]", i), 32'(tx_w[i]), 32'(etx[i]));
            check($sformatf("ready[%0d]", i), 32'(rdy_w[i]), 32'(erdy[i]));
         end
      end
   end

   function automatic logic [7:0] decode(input int i, input int off);
      logic [7:0] d;
      for (int k = 0; k < 8; k++) d[k] = cap[i][off + (1 + k) * int'(C) + 1];
      return d;
   endfunction

   task automatic clear_cap();
      for (int i = 0; i < 4; i++) cap_n[i] = 0;
   endtask

   // Raise start with a byte and hold it until dut0 shows ready low.
   task automatic send(input logic [7:0] b);
      bit seen;
      seen = 1'b0;
      clear_cap();
      start = 1'b1;
      din   = b;
      for (int n = 0; n < 20 && !seen; n++) begin
         @(negedge clk);
         if (!rdy_w[0]) seen = 1'b1;
      end
      check("accept", 32'(seen), 32'd1);
      start = 1'b0;
   endtask

   task automatic wait_idle();
      bit done;
      done = 1'b0;
      for (int n = 0; n < 200 && !done; n++) begin
         if (rdy_w == 4'hF) done = 1'b1;
         else @(negedge clk);
      end
      check("idle_reached", 32'(done), 32'd1);
      @(negedge clk);
   endtask

   typedef struct {
      logic [7:0]  b;
      logic        pe;
      logic        po;
      int unsigned len_np;
      int unsigned len_p;
   } vec_t;

   vec_t tbl [7];

   initial begin
      int hc;
      int first_one;
      int ones_cnt;
      bit seen;

      tbl[0] = '{8'hA5, 1'b0, 1'b1, 40, 44};
      tbl[1] = '{8'h01, 1'b1, 1'b0, 40, 44};
      tbl[2] = '{8'hFF, 1'b0, 1'b1, 40, 44};
      tbl[3] = '{8'h00, 1'b0, 1'b1, 40, 44};
      tbl[4] = '{8'h3C, 1'b0, 1'b1, 40, 44};
      tbl[5] = '{8'h80, 1'b1, 1'b0, 40, 44};
      tbl[6] = '{8'h7F, 1'b1, 1'b0, 40, 44};

      clear_cap();
      repeat (3) @(negedge clk);
      chk_en = 1'b1;
      check("reset_tx", 32'(tx_w), 32'hF);
      check("reset_ready", 32'(rdy_w), 32'hF);
      reset = 1'b0;
      @(negedge clk);

      for (int j = 0; j < 7; j++) begin
         send(tbl[j].b);
         wait_idle();
         check($sformatf("byte0_%02h", tbl[j].b), 32'(decode(0, 0)), 32'(tbl[j].b));
         check($sformatf("startbit0_%02h", tbl[j].b), 32'(cap[0][1]), 32'd0);
         check($sformatf("stopbit0_%02h", tbl[j].b), 32'(cap[0][9 * C + 1]), 32'd1);
         check($sformatf("len0_%02h", tbl[j].b), 32'(cap_n[0]), 32'(tbl[j].len_np));
         check($sformatf("len1_%02h", tbl[j].b), 32'(cap_n[1]), 32'(tbl[j].len_p));
         check($sformatf("len3_%02h", tbl[j].b), 32'(cap_n[3]), 32'(tbl[j].len_p));
         check($sformatf("even_%02h", tbl[j].b), 32'(cap[1][9 * C + 1]), 32'(tbl[j].pe));
         check($sformatf("odd_%02h", tbl[j].b), 32'(cap[2][9 * C + 1]), 32'(tbl[j].po));
         if (tbl[j].b == 8'h00) begin
            first_one = -1;
            ones_cnt  = 0;
            for (int k = 0; k < cap_n[3]; k++) begin
               if (cap[3][k]) begin
                  ones_cnt++;
                  if (first_one < 0) first_one = k;
               end
            end
            check("stop2_low_len", 32'(first_one), 32'd36);
            check("stop2_high_len", 32'(ones_cnt), 32'd8);
         end
      end

      // Back-to-back frames with start held high throughout.
      clear_cap();
      start = 1'b1;
      din   = 8'h55;
      seen  = 1'b0;
      for (int n = 0; n < 20 && !seen; n++) begin
         @(negedge clk);
         if (!rdy_w[0]) seen = 1'b1;
      end
      check("b2b_accept", 32'(seen), 32'd1);
      din  = 8'hAA;
      seen = 1'b0;
      for (int n = 0; n < 100 && !seen; n++) begin
         @(negedge clk);
         if (rdy_w[0]) seen = 1'b1;
      end
      check("b2b_ready_rise", 32'(seen), 32'd1);
      hc = 0;
      while (rdy_w[0] && hc < 10) begin
         hc++;
         @(negedge clk);
      end
      check("b2b_idle_cycles", 32'(hc), 32'd1);
      start = 1'b0;
      wait_idle();
      check("b2b_first", 32'(decode(0, 0)), 32'h55);
      check("b2b_second", 32'(decode(0, 40)), 32'hAA);
      check("b2b_len", 32'(cap_n[0]), 32'd80);

      // Byte changed and start re-pulsed mid-frame.
      send(8'h5A);
      repeat (10) @(negedge clk);
      din   = 8'h99;
      start = 1'b1;
      repeat (2) @(negedge clk);
      start = 1'b0;
      din   = 8'h00;
      wait_idle();
      check("midframe_byte", 32'(decode(0, 0)), 32'h5A);
      check("midframe_len", 32'(cap_n[0]), 32'd40);

      // Reset during the 13th cycle of a 0xFF frame, then a clean 0x3C frame.
      send(8'hFF);
      repeat (12) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("abort_tx", 32'(tx_w), 32'hF);
      check("abort_ready", 32'(rdy_w), 32'hF);
      reset = 1'b0;
      @(negedge clk);
      send(8'h3C);
      wait_idle();
      check("post_reset_byte", 32'(decode(0, 0)), 32'h3C);
      check("post_reset_len", 32'(cap_n[0]), 32'd40);

      // Reset and start together: reset must win.
      reset = 1'b1;
      start = 1'b1;
      din   = 8'hC3;
      @(negedge clk);
      check("rst_start_ready", 32'(rdy_w), 32'hF);
      reset = 1'b0;
      start = 1'b0;
      @(negedge clk);
      check("rst_start_ready2", 32'(rdy_w), 32'hF);
      check("rst_start_tx2", 32'(tx_w), 32'hF);

      // Randomized traffic with occasional resets, checked by the model.
      for (int n = 0; n < 1500; n++) begin
         start = ($urandom_range(0, 3) == 0);
         din   = 8'($urandom);
         reset = ($urandom_range(0, 299) == 0);
         @(negedge clk);
      end
      reset = 1'b0;
      start = 1'b0;
      wait_idle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_byte_transmitter.md
UART_BYTE_TRANSMITTER -- requirements
Module: uart_byte_transmitter

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, clock cycles per serial bit (legal range 2..65535).
REQ-002 Parameter PARITY, default 0, parity mode: 0 none, 1 even, 2 odd.
REQ-003 Parameter STOP_BITS, default 1, stop bits per frame, 1 or 2.
REQ-004 clk  input  1  sole clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 tran_interface_start  input  1  byte-send request from the packet transmitter, level-sampled.
REQ-007 tran_interface_out_byte  input  8  byte to send, valid while start is high.
REQ-008 tran_interface_ready  output  1  high = idle and able to accept a byte.
REQ-009 tx  output  1  serial line, idle high.

Function
REQ-010 States SHALL be IDLE, START, DATA, PARITY, STOP; PARITY is skipped when PARITY=0.
REQ-011 In IDLE with start=1 at edge N: latch the byte and go to START; at N+1 tx=0 and ready=0.
REQ-012 In every state except IDLE, start SHALL be ignored, and input-byte changes SHALL NOT affect the frame in flight.
REQ-013 Each bit SHALL be held on tx for exactly CLKS_PER_BIT cycles, timed by a counter that reloads at every bit boundary.
REQ-014 DATA SHALL send 8 bits LSB first, using a 3-bit index that must not wrap into a ninth bit.
REQ-015 The parity bit SHALL be the XOR of the latched byte (even) or its complement (odd).
REQ-016 STOP SHALL drive tx=1 for STOP_BITS*CLKS_PER_BIT cycles, then enter IDLE.
REQ-017 Frame length SHALL be F = (1+8+P+STOP_BITS)*CLKS_PER_BIT cycles, where P=1 if parity is enabled, else 0.
REQ-018 ready SHALL be 0 from N+1 through N+F and return to 1 at N+1+F, so ready is low for at least one cycle per byte.
REQ-019 If start is still high at the cycle ready returns to 1, a new frame SHALL be accepted, giving back-to-back frames with exactly 1 idle-high cycle between them.
REQ-020 tx and ready SHALL be registered outputs with no combinational path from the inputs.
REQ-021 The upstream handshake contract SHALL be: upstream holds start until it sees ready=0, then drops it, and treats the rising edge of ready as "byte done".

Reset
REQ-022 When reset=1 at a clock edge, the next cycle SHALL show state=IDLE, tx=1, ready=1, counters=0 and the latched byte=0.
REQ-023 Reset mid-frame SHALL abort the frame immediately (tx=1 the next cycle) with no partial completion signalled.
REQ-024 When reset and start are both high in the same cycle, reset SHALL win and the byte SHALL NOT be accepted.

Structure
REQ-025 The shared package/include uart_defs SHALL hold the parity encodings (PARITY_NONE=0, PARITY_EVEN=1, PARITY_ODD=2) and the FSM state encodings.
REQ-026 One sub-module, uart_baud_tick, SHALL generate the per-bit tick (CLKS_PER_BIT counter with a sync restart input); the FSM SHALL stay in the top module.
REQ-027 Counter widths SHALL be derived from the parameters with clog2, never hard-coded.

Verification (CLKS_PER_BIT=4, STOP_BITS=1 unless stated)
REQ-028 PARITY=0, byte 0xA5, start pulsed until ready=0 -> tx bits 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles; ready low for 40 cycles.
REQ-029 PARITY=1 then PARITY=2, byte 0xA5 -> parity bit 0 then 1; frame 44 cycles; 0x01 under even parity -> parity bit 1.
REQ-030 Start held high continuously with bytes 0x55 then 0xAA -> two frames separated by exactly one idle-high cycle; ready rises between them.
REQ-031 Byte changed and start re-pulsed mid-frame -> original byte transmitted intact; the extra start is ignored.
REQ-032 Reset asserted at cycle 13 of a 0xFF frame -> tx=1 and ready=1 the next cycle; a subsequent 0x3C frame is correct.
REQ-033 STOP_BITS=2, byte 0x00 -> tx low for 36 cycles, then high for 8 cycles before ready=1.
